// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the DMEM arbiter.
//   size_t         - access size, same encoding as DMEM BYTE_SEL
//   resp_state_t   - response pipeline state
//   is_misaligned  - flags SIZE=11 and misaligned half/word accesses
package dmem_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } resp_state_t;

   // SIZE=11 has no DMEM meaning, so it is treated like a misalignment.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb: 2-way grant logic with round-robin or fixed priority.
//   clk_i, rst_ni  - clock, async active-low reset
//   req_i[1:0]     - requests (bit n = port n)
//   gnt_o[1:0]     - one-hot or zero grant, combinational, subset of req_i
module dmem_rr_arb #(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_last_q, rr_last_d;

   // Grant decode; on a tie round-robin favours the port that did not win last.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01: gnt_o = 2'b01;
         2'b10: gnt_o = 2'b10;
         2'b11: begin
            if ((FIXED_PRIO != 0) || rr_last_q) begin
               gnt_o = 2'b01;
            end else begin
               gnt_o = 2'b10;
            end
         end
         default: gnt_o = 2'b00;
      endcase
   end

   // Remember the last winner; idle cycles keep the previous value.
   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt_o[1]) begin
         rr_last_d = 1'b1;
      end else if (gnt_o[0]) begin
         rr_last_d = 1'b0;
      end else begin
         rr_last_d = rr_last_q;
      end
   end

   // Reset value 1 lets port 0 win the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-ported DMEM.
//   clk_i, rst_ni          - clock, async active-low reset
//   pN_req_i .. pN_wdata_i - port N request (0 = LSU, 1 = debug/DMA)
//   pN_gnt_o               - combinational grant, transfer on req & gnt
//   pN_rvalid_o/rdata_o/err_o - one-cycle response, one cycle after transfer
//   dmem_*_o               - DMEM control/address/data pins
//   dmem_data_out_i        - DMEM read data, valid the cycle after RDEN
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              p0_req_i,
   input  logic              p0_we_i,
   input  logic [1:0]        p0_size_i,
   input  logic              p0_sign_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   output logic              p0_gnt_o,
   output logic              p0_rvalid_o,
   output logic [DATA_W-1:0] p0_rdata_o,
   output logic              p0_err_o,
   input  logic              p1_req_i,
   input  logic              p1_we_i,
   input  logic [1:0]        p1_size_i,
   input  logic              p1_sign_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   output logic              p1_gnt_o,
   output logic              p1_rvalid_o,
   output logic [DATA_W-1:0] p1_rdata_o,
   output logic              p1_err_o,
   output logic              dmem_rden_o,
   output logic              dmem_wen_o,
   output logic [1:0]        dmem_byte_sel_o,
   output logic              dmem_sign_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_data_in_o,
   input  logic [DATA_W-1:0] dmem_data_out_i
);

   logic [1:0]        req_s, gnt_s;
   logic              xfer_s, illegal_s;
   logic              sel_we_s, sel_sign_s;
   logic [1:0]        sel_size_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s, rdata_s;
   resp_state_t       state_q, state_d;
   logic              owner_q, owner_d, err_q, err_d, is_rd_q, is_rd_d;

   // Requests are masked during reset so no grant or DMEM strobe leaks out.
   assign req_s = {p1_req_i, p0_req_i} & {2{rst_ni}};

   dmem_rr_arb #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (req_s),
      .gnt_o  (gnt_s)
   );

   assign p0_gnt_o = gnt_s[0];
   assign p1_gnt_o = gnt_s[1];
   assign xfer_s   = |gnt_s;

   // Select the granted port's fields.
   always_comb begin
      if (gnt_s[1]) begin
         sel_we_s    = p1_we_i;
         sel_size_s  = p1_size_i;
         sel_sign_s  = p1_sign_i;
         sel_addr_s  = p1_addr_i;
         sel_wdata_s = p1_wdata_i;
      end else begin
         sel_we_s    = p0_we_i;
         sel_size_s  = p0_size_i;
         sel_sign_s  = p0_sign_i;
         sel_addr_s  = p0_addr_i;
         sel_wdata_s = p0_wdata_i;
      end
   end

   assign illegal_s = is_misaligned(sel_size_s, sel_addr_s[1:0]);

   // DMEM pins carry only legal granted accesses; everything else drives zero.
   always_comb begin
      dmem_rden_o     = 1'b0;
      dmem_wen_o      = 1'b0;
      dmem_byte_sel_o = 2'b00;
      dmem_sign_o     = 1'b0;
      dmem_addr_o     = '0;
      dmem_data_in_o  = '0;
      if (xfer_s && !illegal_s) begin
         dmem_rden_o     = ~sel_we_s;
         dmem_wen_o      = sel_we_s;
         dmem_byte_sel_o = sel_size_s;
         dmem_sign_o     = sel_sign_s;
         dmem_addr_o     = sel_addr_s;
         dmem_data_in_o  = sel_wdata_s;
      end else begin
         dmem_rden_o = 1'b0;
      end
   end

   // Response FSM next state and captured response attributes.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      err_d   = err_q;
      is_rd_d = is_rd_q;
      case (state_q)
         ST_IDLE: if (xfer_s) state_d = ST_RESP; else state_d = ST_IDLE;
         ST_RESP: if (xfer_s) state_d = ST_RESP; else state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (xfer_s) begin
         owner_d = gnt_s[1];
         err_d   = illegal_s;
         is_rd_d = ~sel_we_s;
      end else begin
         owner_d = owner_q;
      end
   end

   // Response register; reset discards any response still in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         err_q   <= 1'b0;
         is_rd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         err_q   <= err_d;
         is_rd_q <= is_rd_d;
      end
   end

   // DMEM read data is only meaningful for legal loads.
   assign rdata_s     = (is_rd_q && !err_q) ? dmem_data_out_i : '0;
   assign p0_rvalid_o = (state_q == ST_RESP) && !owner_q;
   assign p1_rvalid_o = (state_q == ST_RESP) && owner_q;
   assign p0_err_o    = p0_rvalid_o & err_q;
   assign p1_err_o    = p1_rvalid_o & err_q;
   assign p0_rdata_o  = p0_rvalid_o ? rdata_s : '0;
   assign p1_rdata_o  = p1_rvalid_o ? rdata_s : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural DMEM.
module tb_dmem_arbiter;

   typedef struct packed {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic p0_req, p0_we, p0_sign, p1_req, p1_we, p1_sign;
   logic [1:0] p0_size, p1_size;
   logic [13:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;

   logic r_p0_gnt, r_p0_rvalid, r_p0_err, r_p1_gnt, r_p1_rvalid, r_p1_err;
   logic [31:0] r_p0_rdata, r_p1_rdata;
   logic r_rden, r_wen, r_sign;
   logic [1:0] r_bsel;
   logic [13:0] r_addr;
   logic [31:0] r_din, r_dout;

   logic f_p0_gnt, f_p0_rvalid, f_p0_err, f_p1_gnt, f_p1_rvalid, f_p1_err;
   logic [31:0] f_p0_rdata, f_p1_rdata;
   logic f_rden, f_wen, f_sign;
   logic [1:0] f_bsel;
   logic [13:0] f_addr;
   logic [31:0] f_din;
   logic [31:0] f_dout = 32'h0;

   logic [7:0] dmem_arr [0:16383];
   logic [7:0] refm [0:16383];
   exp_t sb [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
      .clk_i(clk), .rst_ni(rst_n),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_size_i(p0_size), .p0_sign_i(p0_sign),
      .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_gnt_o(r_p0_gnt),
      .p0_rvalid_o(r_p0_rvalid), .p0_rdata_o(r_p0_rdata), .p0_err_o(r_p0_err),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_size_i(p1_size), .p1_sign_i(p1_sign),
      .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_gnt_o(r_p1_gnt),
      .p1_rvalid_o(r_p1_rvalid), .p1_rdata_o(r_p1_rdata), .p1_err_o(r_p1_err),
      .dmem_rden_o(r_rden), .dmem_wen_o(r_wen), .dmem_byte_sel_o(r_bsel),
      .dmem_sign_o(r_sign), .dmem_addr_o(r_addr), .dmem_data_in_o(r_din),
      .dmem_data_out_i(r_dout)
   );

   dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
      .clk_i(clk), .rst_ni(rst_n),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_size_i(p0_size), .p0_sign_i(p0_sign),
      .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_gnt_o(f_p0_gnt),
      .p0_rvalid_o(f_p0_rvalid), .p0_rdata_o(f_p0_rdata), .p0_err_o(f_p0_err),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_size_i(p1_size), .p1_sign_i(p1_sign),
      .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_gnt_o(f_p1_gnt),
      .p1_rvalid_o(f_p1_rvalid), .p1_rdata_o(f_p1_rdata), .p1_err_o(f_p1_err),
      .dmem_rden_o(f_rden), .dmem_wen_o(f_wen), .dmem_byte_sel_o(f_bsel),
      .dmem_sign_o(f_sign), .dmem_addr_o(f_addr), .dmem_data_in_o(f_din),
      .dmem_data_out_i(f_dout)
   );

   // Little-endian extraction with optional sign extension.
   function automatic logic [31:0] rd_ext(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [1:0] size, input logic sign);
      case (size)
         2'b00:   return sign ? {{24{b0[7]}}, b0} : {24'h0, b0};
         2'b01:   return sign ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   // Behavioural DMEM: write on WEN, registered read data after RDEN.
   always @(posedge clk) begin
      if (r_wen) begin
         dmem_arr[r_addr] <= r_din[7:0];
         if (r_bsel != 2'b00) dmem_arr[r_addr + 14'd1] <= r_din[15:8];
         if (r_bsel == 2'b10) begin
            dmem_arr[r_addr + 14'd2] <= r_din[23:16];
            dmem_arr[r_addr + 14'd3] <= r_din[31:24];
         end
      end
      if (r_rden) begin
         r_dout <= rd_ext(dmem_arr[r_addr], dmem_arr[r_addr + 14'd1], dmem_arr[r_addr + 14'd2],
                          dmem_arr[r_addr + 14'd3], r_bsel, r_sign);
      end
   end

   task automatic drive(input logic port, input logic req, input logic we, input logic [1:0] size,
                        input logic sign, input logic [13:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_req = req; p1_we = we; p1_size = size; p1_sign = sign; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = req; p0_we = we; p0_size = size; p0_sign = sign; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 14'h0, 32'h0);
   endtask

   // Reference model: predicts the response of one transfer and updates refm.
   task automatic model_push(input logic port, input logic we, input logic [1:0] size,
                             input logic sign, input logic [13:0] addr, input logic [31:0] wdata);
      exp_t e;
      e.port  = port;
      e.err   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
      e.rdata = 32'h0;
      if (!e.err) begin
         if (we) begin
            refm[addr] = wdata[7:0];
            if (size != 2'b00) refm[addr + 14'd1] = wdata[15:8];
            if (size == 2'b10) begin
               refm[addr + 14'd2] = wdata[23:16];
               refm[addr + 14'd3] = wdata[31:24];
            end
         end else begin
            e.rdata = rd_ext(refm[addr], refm[addr + 14'd1], refm[addr + 14'd2],
                             refm[addr + 14'd3], size, sign);
         end
      end
      sb.push_back(e);
   endtask

   // Called at the sampling point of the cycle: records what transfers at the next edge.
   task automatic sb_issue();
      if (p0_req && r_p0_gnt) model_push(1'b0, p0_we, p0_size, p0_sign, p0_addr, p0_wdata);
      if (p1_req && r_p1_gnt) model_push(1'b1, p1_we, p1_size, p1_sign, p1_addr, p1_wdata);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 14'h4, 32'h12345678);
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 14'h8, 32'h0);
      @(negedge clk);
      checks++;
      if ({r_p0_gnt, r_p1_gnt, r_p0_rvalid, r_p1_rvalid, r_p0_err, r_p1_err, r_rden, r_wen} !== 8'h00 ||
          r_addr !== 14'h0 || r_din !== 32'h0 || r_p0_rdata !== 32'h0 || r_p1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b%b rv=%b%b rden=%b wen=%b addr=%h din=%h, required all 0",
                  r_p0_gnt, r_p1_gnt, r_p0_rvalid, r_p1_rvalid, r_rden, r_wen, r_addr, r_din);
      end
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_arbitration();
      logic [1:0] rr_g [0:5];
      logic [1:0] fp_g [0:5];
      logic [1:0] fp_rv;
      exp_t e;
      rr_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
      fp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         drive(1'b0, (c < 4), 1'b0, 2'b10, 1'b0, 14'h0, 32'h0);
         drive(1'b1, (c < 5), 1'b0, 2'b10, 1'b0, 14'h10, 32'h0);
         @(negedge clk);
         checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if ({r_p1_rvalid, r_p0_rvalid} !== (e.port ? 2'b10 : 2'b01) ||
                (e.port ? r_p1_rdata : r_p0_rdata) !== e.rdata || (e.port ? r_p0_rdata : r_p1_rdata) !== 32'h0 ||
                (e.port ? r_p1_err : r_p0_err) !== e.err) begin
               errors++;
               $display("FAIL arb_resp c%0d: rv=%b%b d0=%h d1=%h err=%b%b, required port%0d d=%h err=%b",
                        c, r_p1_rvalid, r_p0_rvalid, r_p0_rdata, r_p1_rdata, r_p1_err, r_p0_err, e.port, e.rdata, e.err);
            end
         end else if ({r_p1_rvalid, r_p0_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL arb_resp c%0d: rv=%b%b, required 00", c, r_p1_rvalid, r_p0_rvalid);
         end
         checks++;
         if ({r_p1_gnt, r_p0_gnt} !== rr_g[c]) begin
            errors++;
            $display("FAIL rr_grant c%0d: gnt=%b, required %b", c, {r_p1_gnt, r_p0_gnt}, rr_g[c]);
         end
         fp_rv = (c == 0) ? 2'b00 : fp_g[c-1];
         checks++;
         if ({f_p1_gnt, f_p0_gnt} !== fp_g[c] || {f_p1_rvalid, f_p0_rvalid} !== fp_rv ||
             f_rden !== (|fp_g[c]) || f_wen !== 1'b0 || f_p0_rdata !== 32'h0 || f_p1_rdata !== 32'h0 ||
             {f_p1_err, f_p0_err} !== 2'b00) begin
            errors++;
            $display("FAIL fixed_prio c%0d: gnt=%b rv=%b rden=%b wen=%b, required gnt=%b rv=%b rden=%b wen=0",
                     c, {f_p1_gnt, f_p0_gnt}, {f_p1_rvalid, f_p0_rvalid}, f_rden, f_wen, fp_g[c], fp_rv, |fp_g[c]);
         end
         checks++;
         if (f_rden && f_addr !== (fp_g[c][1] ? 14'h10 : 14'h0)) begin
            errors++;
            $display("FAIL fixed_addr c%0d: addr=%h", c, f_addr);
         end
         sb_issue();
      end
   endtask

   // Runs a list of single-port accesses; one cycle each, last cycle idle.
   // dm = required {wen,rden} in the issue cycle; xd = explicit required rdata of the response seen this cycle.
   task automatic run_seq(input string name, input int n, input logic [0:7] port, input logic [0:7] we,
                          input logic [1:0] size [0:7], input logic [0:7] sign, input logic [13:0] addr [0:7],
                          input logic [31:0] wd [0:7], input logic [1:0] dm [0:7],
                          input logic [0:7] xchk, input logic [31:0] xd [0:7], input logic [0:7] xerr);
      exp_t e;
      for (int c = 0; c <= n; c++) begin
         @(posedge clk); #1;
         idle();
         if (c < n) drive(port[c], 1'b1, we[c], size[c], sign[c], addr[c], wd[c]);
         @(negedge clk);
         checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if ({r_p1_rvalid, r_p0_rvalid} !== (e.port ? 2'b10 : 2'b01) ||
                (e.port ? r_p1_rdata : r_p0_rdata) !== e.rdata || (e.port ? r_p0_rdata : r_p1_rdata) !== 32'h0 ||
                (e.port ? r_p1_err : r_p0_err) !== e.err) begin
               errors++;
               $display("FAIL %s_resp c%0d: rv=%b%b d0=%h d1=%h err=%b%b, required port%0d d=%h err=%b",
                        name, c, r_p1_rvalid, r_p0_rvalid, r_p0_rdata, r_p1_rdata, r_p1_err, r_p0_err,
                        e.port, e.rdata, e.err);
            end
         end else if ({r_p1_rvalid, r_p0_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL %s_resp c%0d: rv=%b%b, required 00", name, c, r_p1_rvalid, r_p0_rvalid);
         end
         if (c > 0 && xchk[c-1]) begin
            checks++;
            if ((port[c-1] ? r_p1_rdata : r_p0_rdata) !== xd[c-1] ||
                (port[c-1] ? r_p1_err : r_p0_err) !== xerr[c-1]) begin
               errors++;
               $display("FAIL %s_value c%0d: rdata=%h err=%b, required %h err=%b", name, c,
                        port[c-1] ? r_p1_rdata : r_p0_rdata, port[c-1] ? r_p1_err : r_p0_err, xd[c-1], xerr[c-1]);
            end
         end
         if (c < n) begin
            checks++;
            if ((port[c] ? r_p1_gnt : r_p0_gnt) !== 1'b1 || {r_wen, r_rden} !== dm[c] ||
                (dm[c] != 2'b00 && (r_addr !== addr[c] || r_bsel !== size[c])) ||
                (dm[c] == 2'b10 && r_din !== wd[c]) || (dm[c] == 2'b00 && r_addr !== 14'h0)) begin
               errors++;
               $display("FAIL %s_issue c%0d: gnt=%b%b wen=%b rden=%b addr=%h bsel=%b din=%h, required wen/rden=%b addr=%h",
                        name, c, r_p1_gnt, r_p0_gnt, r_wen, r_rden, r_addr, r_bsel, r_din, dm[c], addr[c]);
            end
         end
         sb_issue();
      end
   endtask

   task automatic test_store_load();
      run_seq("store_load", 2, 8'b0000_0000, 8'b1000_0000,
              '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 8'b0,
              '{14'h4, 14'h4, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0},
              '{32'hdeadbeef, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
              '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
              8'b1100_0000, '{32'h0, 32'hdeadbeef, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 8'b0);
   endtask

   task automatic test_sign_ext();
      run_seq("sign_ext", 3, 8'b1110_0000, 8'b1000_0000,
              '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 8'b0100_0000,
              '{14'h8, 14'h8, 14'h8, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0},
              '{32'h000000ef, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
              '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
              8'b0110_0000, '{32'h0, 32'hffffffef, 32'h000000ef, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 8'b0);
   endtask

   task automatic test_misaligned();
      run_seq("misaligned", 4, 8'b1101_0000, 8'b1000_0000,
              '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00}, 8'b0,
              '{14'h9, 14'hA, 14'h0, 14'h8, 14'h0, 14'h0, 14'h0, 14'h0},
              '{32'h00001234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
              '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00},
              8'b1111_0000, '{32'h0, 32'h0, 32'h0, 32'h000000ef, 32'h0, 32'h0, 32'h0, 32'h0},
              8'b1110_0000);
   endtask

   task automatic test_reset_mid_response();
      exp_t e;
      @(posedge clk); #1;
      idle();
      drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 14'h4, 32'h0);
      @(negedge clk);
      sb_issue();
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle();
      sb.delete();
      @(negedge clk);
      checks++;
      if ({r_p1_rvalid, r_p0_rvalid} !== 2'b00 || r_p0_rdata !== 32'h0 || r_p1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_drop: rv=%b%b d0=%h, required 00 and 0", r_p1_rvalid, r_p0_rvalid, r_p0_rdata);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         drive(1'b0, (c == 0), 1'b0, 2'b10, 1'b0, 14'h4, 32'h0);
         drive(1'b1, (c < 2), 1'b0, 2'b10, 1'b0, 14'h8, 32'h0);
         @(negedge clk);
         checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if ({r_p1_rvalid, r_p0_rvalid} !== (e.port ? 2'b10 : 2'b01) ||
                (e.port ? r_p1_rdata : r_p0_rdata) !== e.rdata || (e.port ? r_p1_err : r_p0_err) !== e.err) begin
               errors++;
               $display("FAIL rst_mid_resp c%0d: rv=%b%b d0=%h d1=%h, required port%0d d=%h",
                        c, r_p1_rvalid, r_p0_rvalid, r_p0_rdata, r_p1_rdata, e.port, e.rdata);
            end
         end else if ({r_p1_rvalid, r_p0_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_resp c%0d: rv=%b%b, required 00", c, r_p1_rvalid, r_p0_rvalid);
         end
         if (c < 2) begin
            checks++;
            if ({r_p1_gnt, r_p0_gnt} !== ((c == 0) ? 2'b01 : 2'b10)) begin
               errors++;
               $display("FAIL rst_mid_grant c%0d: gnt=%b, required %b", c, {r_p1_gnt, r_p0_gnt},
                        (c == 0) ? 2'b01 : 2'b10);
            end
         end
         sb_issue();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16384; i++) begin
         dmem_arr[i] = 8'h00;
         refm[i]     = 8'h00;
      end
      r_dout = 32'h0;
      test_reset();
      test_arbitration();
      test_store_load();
      test_sign_ext();
      test_misaligned();
      test_reset_mid_response();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported DMEM.
- Port 0 is the core load/store unit; port 1 is the debug/DMA port.
- Grants one access per cycle, drives the DMEM control/address/data pins and routes DMEM_DATA_OUT back to the owning port one cycle later.
- Rejects misaligned accesses locally with an error response; such accesses never reach DMEM.

Parameters:
ADDR_W, 14, byte address width (matches DMEM ADDR)
DATA_W, 32, data width (matches DMEM DATA_IN/DATA_OUT)
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
Pn_REQ  in  1  port n (n=0,1) request; held with fields stable until Pn_GNT
Pn_WE  in  1  1 = store, 0 = load
Pn_SIZE  in  2  00 byte, 01 half, 10 word (DMEM BYTE_SEL encoding); 11 illegal
Pn_SIGN  in  1  sign-extend loads (byte/half)
Pn_ADDR  in  ADDR_W  byte address
Pn_WDATA  in  DATA_W  store data, right-aligned
Pn_GNT  out  1  combinational; request transfers at the edge where Pn_REQ & Pn_GNT
Pn_RVALID  out  1  one-cycle response pulse (loads and stores)
Pn_RDATA  out  DATA_W  load data, valid with Pn_RVALID; 0 for stores and errors
Pn_ERR  out  1  valid with Pn_RVALID; misaligned or SIZE=11
DMEM_RDEN  out  1  to DMEM RDEN
DMEM_WEN  out  1  to DMEM WEN
DMEM_BYTE_SEL  out  2  to DMEM BYTE_SEL
DMEM_SIGN  out  1  to DMEM SIGN
DMEM_ADDR  out  ADDR_W  to DMEM ADDR
DMEM_DATA_IN  out  DATA_W  to DMEM DATA_IN
DMEM_DATA_OUT  in  DATA_W  from DMEM; valid the cycle after a RDEN edge

Behaviour:
- Reset (async, RST_N=0): all outputs 0, rr_last = 1 (so port 0 wins the first tie), resp_valid = 0, resp_owner = 0, resp_err = 0, resp_is_rd = 0. Reset mid-response drops the pending response; no RVALID is ever issued for it.
- Arbitration (combinational, every cycle):
  - Only one REQ high: grant it.
  - Both high, FIXED_PRIO=1: grant port 0.
  - Both high, FIXED_PRIO=0: grant the port != rr_last.
  - rr_last updates to the granted port at each transfer.
  - Starvation bound under round-robin: 1 cycle.
- Legality check on the granted request (combinational):
  - Illegal when SIZE=11, SIZE=01 with ADDR[0]=1, or SIZE=10 with ADDR[1:0]!=00.
- DMEM drive in the transfer cycle:
  - Legal request: DMEM_RDEN=~WE, DMEM_WEN=WE; BYTE_SEL, SIGN, ADDR and WDATA pass through.
  - Illegal request or no grant: RDEN=WEN=0 and all other DMEM outputs 0. A store is never written unless legal.
- Response pipeline (one register stage, latency exactly 1):
  - At each transfer edge: resp_valid=1; capture owner, error flag and is_rd.
  - Next cycle: Pn_RVALID=1 for owner only; Pn_ERR=resp_err.
  - Pn_RDATA = DMEM_DATA_OUT if is_rd & ~err, else 0. The non-owner sees RVALID=0 and RDATA=0.
  - resp_valid clears the following cycle unless another transfer occurs.
- Throughput:
  - Back-to-back transfers every cycle; the response of access k overlaps the issue of access k+1.
  - A read issued after a write to the same address returns the new data, relying on DMEM write-then-read ordering.
  - Responses cannot be back-pressured.
- FSM, 2 states on resp_valid:
  - IDLE -> RESP on transfer.
  - RESP -> RESP on transfer.
  - RESP -> IDLE when no transfer.
- Pn_GNT never high without Pn_REQ. At most one GNT high per cycle.

Decomposition:
- Shared package dmem_pkg:
  - size_t enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10).
  - ADDR_W and DATA_W defaults.
  - function is_misaligned(size, addr[1:0]).
- One sub-module, dmem_rr_arb: 2-way round-robin/fixed-priority grant with rr_last register; REQ[1:0] in, GNT[1:0] out.
- Legality check, DMEM mux and response register stay in the top.

Test Plan:
- P0 store word 0xdeadbeef @4, then P0 load word @4 -> DMEM_WEN=1 then RDEN=1; P0_RVALID each following cycle; second RDATA=0xdeadbeef, ERR=0.
- P0 and P1 REQ held high 4 cycles, FIXED_PRIO=0 -> grants P0,P1,P0,P1; RVALID alternates one cycle later.
- Same stimulus, FIXED_PRIO=1 -> P0 granted all 4 cycles; P1_GNT=0 until P0_REQ drops.
- P1 store half @0x0009 and load word @0x000A -> no DMEM_WEN/RDEN; P1_RVALID=1, ERR=1, RDATA=0; DMEM contents unchanged (load word @8 still returns the earlier value).
- P1 store byte 0xef @8, then load byte SIGN=1 @8 -> RDATA=0xffffffef; with SIGN=0 -> 0x000000ef.
- Drop RST_N for a half cycle right after a load transfer -> no RVALID on either port; next simultaneous request is granted to P0.
